pci_target_seq: RTL and testbench

Target-side bus-cycle sequencer for the PCI core. It claims a transaction once the address decoder reports a card hit. It then drives DEVSEL#/TRDY#/STOP# and the target output enable, and paces data phases against the local backend's ready signal. It enforces the PCI initial-latency retry and disconnect rules, and ends with a one-cycle end-of-access pulse that clears the decoder's latched BAR hits.

---
 rtl/pci_target_seq_if.sv | 27 ++
 rtl/pci_target_seq.sv | 143 ++++++++++++++
 tb/tb_pci_target_seq.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pci_target_seq_if.sv
// Target-side PCI control bundle: decoder/bus/backend inputs toward the
// sequencer and the registered target control outputs back out.
interface pci_target_seq_if;
   logic first_cyc;
   logic card_hit;
   logic frame_n;
   logic irdy_n;
   logic lb_ready;
   logic devsel_n;
   logic trdy_n;
   logic stop_n;
   logic ctl_oe;
   logic lb_strobe;
   logic acc_end;

   // bus/decoder/backend side
   modport master (
      output first_cyc, card_hit, frame_n, irdy_n, lb_ready,
      input  devsel_n, trdy_n, stop_n, ctl_oe, lb_strobe, acc_end
   );

   // sequencer side
   modport slave (
      input  first_cyc, card_hit, frame_n, irdy_n, lb_ready,
      output devsel_n, trdy_n, stop_n, ctl_oe, lb_strobe, acc_end
   );
endinterface

// File: rtl/pci_target_seq.sv
// PCI target bus-cycle sequencer: claims on a decoder hit, paces DEVSEL#,
// TRDY#, STOP# against the backend, applies initial-latency retry and
// burst disconnect, and signals end-of-access after turnaround.
module pci_target_seq #(
   parameter int DEVSEL_WAIT = 1,
   parameter int RETRY_LIMIT = 16,
   parameter bit BURST_EN    = 1'b1
) (
   input logic       clk,
   input logic       rst,
   pci_target_seq_if.slave bus
);
   typedef enum logic [2:0] {IDLE, DECODE, WAIT, DATA, STOP, TURN} state_t;

   localparam logic [4:0] LAT_MAX   = 5'(RETRY_LIMIT - 1);
   localparam logic [1:0] WAIT_LOAD = 2'(DEVSEL_WAIT);

   state_t     state, state_nx;
   logic [4:0] lat, lat_nx;
   logic [1:0] wcnt, wcnt_nx;
   logic       devsel_q, devsel_nx;
   logic       trdy_q, trdy_nx;
   logic       stop_q, stop_nx;
   logic       oe_q, oe_nx;
   logic       strobe_q, strobe_nx;
   logic       end_q, end_nx;
   logic       phase_done;

   // a data phase completes when both ready strobes are low this clock
   assign phase_done = !bus.irdy_n && !trdy_q;

   // next state and next registered outputs; default is hold, pulses clear
   always_comb begin
      state_nx  = state;
      lat_nx    = lat;
      wcnt_nx   = wcnt;
      devsel_nx = devsel_q;
      trdy_nx   = trdy_q;
      stop_nx   = stop_q;
      oe_nx     = oe_q;
      strobe_nx = 1'b0;
      end_nx    = 1'b0;
      case (state)
         IDLE: begin
            // first_cyc without a hit leaves everything untouched
            if (bus.first_cyc && bus.card_hit) begin
               state_nx = DECODE;
               oe_nx    = 1'b1;
               lat_nx   = 5'd0;
               wcnt_nx  = WAIT_LOAD;
            end
         end
         DECODE: begin
            lat_nx = lat + 5'd1;
            if (wcnt == 2'd0) begin
               state_nx  = WAIT;
               devsel_nx = 1'b0;
            end else begin
               wcnt_nx = wcnt - 2'd1;
            end
         end
         WAIT: begin
            lat_nx = lat + 5'd1;
            // backend readiness takes priority over the retry limit
            if (bus.lb_ready) begin
               state_nx = DATA;
               trdy_nx  = 1'b0;
            end else if (lat == LAT_MAX) begin
               state_nx = STOP;
               stop_nx  = 1'b0;
               trdy_nx  = 1'b1;
            end
         end
         DATA: begin
            if (phase_done) begin
               strobe_nx = 1'b1;
               if (bus.frame_n) begin
                  state_nx  = TURN;
                  devsel_nx = 1'b1;
                  trdy_nx   = 1'b1;
                  stop_nx   = 1'b1;
               end else if (!BURST_EN) begin
                  // disconnect without data: STOP# never carries TRDY#
                  state_nx = STOP;
                  stop_nx  = 1'b0;
                  trdy_nx  = 1'b1;
               end else begin
                  trdy_nx = !bus.lb_ready;
               end
            end else begin
               trdy_nx = !bus.lb_ready;
            end
         end
         STOP: begin
            if (bus.frame_n && !bus.irdy_n) begin
               state_nx  = TURN;
               devsel_nx = 1'b1;
               trdy_nx   = 1'b1;
               stop_nx   = 1'b1;
            end
         end
         TURN: begin
            // drive the lines high for one clock, then release them
            state_nx = IDLE;
            oe_nx    = 1'b0;
            end_nx   = 1'b1;
         end
         default: state_nx = IDLE;
      endcase
   end

   // state, counters and registered outputs; reset aborts without acc_end
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         lat      <= 5'd0;
         wcnt     <= 2'd0;
         devsel_q <= 1'b1;
         trdy_q   <= 1'b1;
         stop_q   <= 1'b1;
         oe_q     <= 1'b0;
         strobe_q <= 1'b0;
         end_q    <= 1'b0;
      end else begin
         state    <= state_nx;
         lat      <= lat_nx;
         wcnt     <= wcnt_nx;
         devsel_q <= devsel_nx;
         trdy_q   <= trdy_nx;
         stop_q   <= stop_nx;
         oe_q     <= oe_nx;
         strobe_q <= strobe_nx;
         end_q    <= end_nx;
      end
   end

   assign bus.devsel_n  = devsel_q;
   assign bus.trdy_n    = trdy_q;
   assign bus.stop_n    = stop_q;
   assign bus.ctl_oe    = oe_q;
   assign bus.lb_strobe = strobe_q;
   assign bus.acc_end   = end_q;
endmodule

// File: tb/tb_pci_target_seq.sv
// Directed bench for pci_target_seq. Output vector order in every
// expectation: {devsel_n, trdy_n, stop_n, ctl_oe, lb_strobe, acc_end}.
module tb_pci_target_seq;
   logic clk;
   logic rst;
   int   total;
   int   bad;
   logic [5:0] sb[$];

   pci_target_seq_if ifa ();
   pci_target_seq_if ifb ();

   pci_target_seq dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa.slave)
   );

   pci_target_seq #(.BURST_EN(1'b0)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // drive one clock of inputs on the selected DUT, queue its expected
   // outputs, then compare after the edge
   task automatic step(input bit sel, input logic fc, input logic ch,
                       input logic fr, input logic ir, input logic rdy,
                       input logic [5:0] exp, input string tag);
      logic [5:0] obs;
      logic [5:0] e;
      if (sel == 1'b0) begin
         ifa.first_cyc = fc; ifa.card_hit = ch; ifa.frame_n = fr;
         ifa.irdy_n = ir;    ifa.lb_ready = rdy;
      end else begin
         ifb.first_cyc = fc; ifb.card_hit = ch; ifb.frame_n = fr;
         ifb.irdy_n = ir;    ifb.lb_ready = rdy;
      end
      sb.push_back(exp);
      @(posedge clk);
      #1;
      if (sel == 1'b0)
         obs = {ifa.devsel_n, ifa.trdy_n, ifa.stop_n, ifa.ctl_oe, ifa.lb_strobe, ifa.acc_end};
      else
         obs = {ifb.devsel_n, ifb.trdy_n, ifb.stop_n, ifb.ctl_oe, ifb.lb_strobe, ifb.acc_end};
      e = sb.pop_front();
      total++;
      assert (obs === e) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, e);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      ifa.first_cyc = 1'b0; ifa.card_hit = 1'b0; ifa.frame_n = 1'b1;
      ifa.irdy_n = 1'b1;    ifa.lb_ready = 1'b0;
      ifb.first_cyc = 1'b0; ifb.card_hit = 1'b0; ifb.frame_n = 1'b1;
      ifb.irdy_n = 1'b1;    ifb.lb_ready = 1'b0;

      // reset state on both instances
      rst = 1'b1;
      step(0, 0, 0, 1, 1, 0, 6'b111000, "reset_a");
      step(1, 0, 0, 1, 1, 0, 6'b111000, "reset_b");
      rst = 1'b0;
      step(0, 0, 0, 1, 1, 0, 6'b111000, "idle_a");

      // single-word read, medium decode, lb_ready held
      step(0, 1, 1, 0, 1, 1, 6'b111100, "rd_e0_claim");
      step(0, 0, 0, 1, 0, 1, 6'b111100, "rd_e1_decode");
      step(0, 0, 0, 1, 0, 1, 6'b011100, "rd_e2_devsel");
      step(0, 0, 0, 1, 0, 1, 6'b001100, "rd_e3_trdy");
      step(0, 0, 0, 1, 0, 1, 6'b111110, "rd_e4_turn_strobe");
      step(0, 0, 0, 1, 1, 1, 6'b111001, "rd_e5_acc_end");
      step(0, 0, 0, 1, 1, 0, 6'b111000, "rd_e6_idle");

      // 4-word burst, backend drops ready for 2 clocks, stray first_cyc ignored
      step(0, 1, 1, 0, 0, 1, 6'b111100, "bw_e0_claim");
      step(0, 0, 0, 0, 0, 1, 6'b111100, "bw_e1_decode");
      step(0, 0, 0, 0, 0, 1, 6'b011100, "bw_e2_devsel");
      step(0, 0, 0, 0, 0, 1, 6'b001100, "bw_e3_trdy");
      step(0, 0, 0, 0, 0, 1, 6'b001110, "bw_e4_word1");
      step(0, 0, 0, 0, 0, 0, 6'b011110, "bw_e5_word2_wait");
      step(0, 1, 1, 0, 0, 0, 6'b011100, "bw_e6_wait_fc_ignored");
      step(0, 0, 0, 0, 0, 1, 6'b001100, "bw_e7_trdy_again");
      step(0, 0, 0, 0, 0, 1, 6'b001110, "bw_e8_word3");
      step(0, 0, 0, 1, 0, 1, 6'b111110, "bw_e9_word4_turn");
      step(0, 0, 0, 1, 1, 0, 6'b111001, "bw_e10_acc_end");
      step(0, 0, 0, 1, 1, 0, 6'b111000, "bw_e11_idle");

      // backend never ready: retry 16 clocks after first_cyc
      step(0, 1, 1, 0, 0, 0, 6'b111100, "rt_e0_claim");
      step(0, 0, 0, 0, 0, 0, 6'b111100, "rt_e1_decode");
      step(0, 0, 0, 0, 0, 0, 6'b011100, "rt_e2_devsel");
      for (int i = 3; i <= 15; i++)
         step(0, 0, 0, 0, 0, 0, 6'b011100, "rt_wait_no_stop");
      step(0, 0, 0, 0, 0, 0, 6'b010100, "rt_e16_stop");
      step(0, 0, 0, 0, 0, 0, 6'b010100, "rt_e17_stop_hold");
      step(0, 0, 0, 1, 0, 0, 6'b111100, "rt_e18_turn");
      step(0, 0, 0, 1, 1, 0, 6'b111001, "rt_e19_acc_end");
      step(0, 0, 0, 1, 1, 0, 6'b111000, "rt_e20_idle");

      // hit not claimed
      step(0, 1, 0, 0, 1, 1, 6'b111000, "miss_e0");
      step(0, 0, 0, 0, 0, 1, 6'b111000, "miss_e1");
      step(0, 0, 0, 1, 1, 1, 6'b111000, "miss_e2");

      // burst disabled: disconnect after the first phase
      step(1, 1, 1, 0, 0, 1, 6'b111100, "nb_e0_claim");
      step(1, 0, 0, 0, 0, 1, 6'b111100, "nb_e1_decode");
      step(1, 0, 0, 0, 0, 1, 6'b011100, "nb_e2_devsel");
      step(1, 0, 0, 0, 0, 1, 6'b001100, "nb_e3_trdy");
      step(1, 0, 0, 0, 0, 1, 6'b010110, "nb_e4_strobe_stop");
      step(1, 0, 0, 0, 0, 1, 6'b010100, "nb_e5_no_strobe");
      step(1, 0, 0, 0, 0, 1, 6'b010100, "nb_e6_stop_hold");
      step(1, 0, 0, 1, 0, 1, 6'b111100, "nb_e7_turn");
      step(1, 0, 0, 1, 1, 0, 6'b111001, "nb_e8_acc_end");
      step(1, 0, 0, 1, 1, 0, 6'b111000, "nb_e9_idle");

      // reset mid-burst, then a clean claim
      step(0, 1, 1, 0, 0, 1, 6'b111100, "rs_e0_claim");
      step(0, 0, 0, 0, 0, 1, 6'b111100, "rs_e1_decode");
      step(0, 0, 0, 0, 0, 1, 6'b011100, "rs_e2_devsel");
      step(0, 0, 0, 0, 0, 1, 6'b001100, "rs_e3_trdy");
      step(0, 0, 0, 0, 0, 1, 6'b001110, "rs_e4_word1");
      rst = 1'b1;
      step(0, 0, 0, 0, 0, 1, 6'b111000, "rs_abort");
      rst = 1'b0;
      step(0, 0, 0, 1, 1, 0, 6'b111000, "rs_no_acc_end");
      step(0, 1, 1, 0, 1, 1, 6'b111100, "rs_reclaim_e0");
      step(0, 0, 0, 1, 0, 1, 6'b111100, "rs_reclaim_e1");
      step(0, 0, 0, 1, 0, 1, 6'b011100, "rs_reclaim_e2");
      step(0, 0, 0, 1, 0, 1, 6'b001100, "rs_reclaim_e3");
      step(0, 0, 0, 1, 0, 1, 6'b111110, "rs_reclaim_e4");
      step(0, 0, 0, 1, 1, 0, 6'b111001, "rs_reclaim_e5");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
